// File: rtl/interp_sequencer.sv
// Sequencer for one NUM_PIXEL x NUM_PIXEL subpixel-interpolation block: row fetch, H/V passes, aligned load strobes.
// Optional macro INTERP_SKIP_VPASS_EN: with frac_y==0 the horizontal pass writes the output directly.
module interp_sequencer #(
  parameter int unsigned NUM_PIXEL = 8,
  parameter int unsigned FIR_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] frac_x,
  input  logic [1:0] frac_y,
  input  logic       row_valid,
  output logic       row_ready,
  output logic       row_load,
  output logic [7:0] sel,
  output logic       hpass_load,
  output logic       out_load,
  output logic [2:0] out_row_idx,
  output logic [1:0] frac_x_q,
  output logic [1:0] frac_y_q,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NUM_ROWS = NUM_PIXEL + 7;
  localparam int unsigned CW       = $clog2(NUM_ROWS + FIR_LAT + 1);

  typedef enum logic [2:0] {IDLE, FILL, HPASS, VPASS, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          issue, issue_vphase;
  logic          skip_v;
  // Delay-line entry: {valid, vpass_phase, sel}
  logic [9:0]    pipe [FIR_LAT];
  logic          p_valid, p_vphase;
  logic [7:0]    p_idx;

`ifdef INTERP_SKIP_VPASS_EN
  assign skip_v = (frac_y_q == 2'd0);
`else
  assign skip_v = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      frac_x_q <= '0;
      frac_y_q <= '0;
      for (int unsigned i = 0; i < FIR_LAT; i++) pipe[i] <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && start) begin
        frac_x_q <= frac_x;
        frac_y_q <= frac_y;
      end
      pipe[0] <= {issue, issue_vphase, sel};
      for (int unsigned i = 1; i < FIR_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    row_ready    = 1'b0;
    sel          = '0;
    issue        = 1'b0;
    issue_vphase = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = FILL;
          cnt_nx   = '0;
        end
      end
      FILL: begin
        row_ready = 1'b1;
        if (row_valid) begin
          if (cnt == CW'(NUM_ROWS - 1)) begin
            state_nx = HPASS;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      HPASS: begin
        if (cnt < CW'(NUM_ROWS)) begin
          issue = 1'b1;
          sel   = 8'(cnt);
        end
        // Tail cycles let the last row drain through the FIR pipe before leaving.
        if (cnt == CW'(NUM_ROWS + FIR_LAT - 1)) begin
          state_nx = skip_v ? DONE : VPASS;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      VPASS: begin
        if (cnt < CW'(NUM_PIXEL)) begin
          issue        = 1'b1;
          issue_vphase = 1'b1;
          sel          = 8'd16 + 8'(cnt);
        end
        if (cnt == CW'(NUM_PIXEL + FIR_LAT - 1)) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign row_load = row_valid & row_ready;
  assign p_valid  = pipe[FIR_LAT-1][9];
  assign p_vphase = pipe[FIR_LAT-1][8];
  assign p_idx    = pipe[FIR_LAT-1][7:0];

  assign hpass_load = p_valid & ~p_vphase;

  always_comb begin
    out_load    = 1'b0;
    out_row_idx = '0;
    if (p_valid && p_vphase) begin
      out_load    = 1'b1;
      out_row_idx = 3'(p_idx - 8'd16);
    end
`ifdef INTERP_SKIP_VPASS_EN
    else if (p_valid && skip_v && p_idx >= 8'd3 && p_idx <= 8'(NUM_PIXEL + 2)) begin
      out_load    = 1'b1;
      out_row_idx = 3'(p_idx - 8'd3);
    end
`endif
  end

endmodule

// File: doc/interp_sequencer.md
Name: interp_sequencer

Overview:
- Controls one 8x8 subpixel-interpolation block for the FIR A/B/C datapath.
- Fetches the 15 reference rows (NUM_PIXEL+7) through a valid/ready handshake and drives the input shift-register load.
- Steps the input-mux select through a horizontal pass and then a vertical pass.
- Produces delay-aligned load strobes for the half-pixel shift registers and the output fillers, and signals completion.

Parameters:
- NUM_PIXEL, 8, output block width and height; input rows = NUM_PIXEL+7.
- FIR_LAT, 2, pipeline latency in cycles from sel to FIR output; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin a block; sampled only in IDLE.
- frac_x  in  2  horizontal fractional position; latched at start.
- frac_y  in  2  vertical fractional position; latched at start.
- row_valid  in  1  upstream row available.
- row_ready  out  1  sequencer accepts a row this cycle.
- row_load  out  1  shift the input shift register; equals row_valid & row_ready.
- sel  out  8  input-mux select: 0..14 selects an input row; 16..23 selects a temp-array column.
- hpass_load  out  1  load the horizontal half-pixel shift registers.
- out_load  out  1  write the FIR outputs into the output fillers.
- out_row_idx  out  3  output row or column index written when out_load=1.
- frac_x_q  out  2  latched frac_x, for FIR tap selection.
- frac_y_q  out  2  latched frac_y, for FIR tap selection.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at block completion.

Behaviour:
- Reset: rst=0 at a clock edge forces IDLE. All outputs are 0 the following cycle, and the FIR_LAT delay line is cleared. Reset mid-block abandons the block; no done pulse is produced.
- States: IDLE, FILL, HPASS, VPASS, DONE.
- IDLE:
  - All strobes are 0.
  - start=1 latches frac_x and frac_y, clears counters, and moves to FILL on the next edge.
  - start is ignored in every other state.
- FILL:
  - row_ready=1.
  - Each accepted row increments row_cnt.
  - row_valid=0 stalls the state with no other effect.
  - When the 15th row is accepted, the next state is HPASS.
  - row_valid is ignored outside FILL, because row_ready=0 there.
- HPASS:
  - sel counts 0..14, one value per cycle, then holds at 0.
  - The state lasts exactly 15+FIR_LAT cycles, then moves to VPASS.
- VPASS:
  - sel counts 16..23, then holds at 0.
  - The state lasts exactly NUM_PIXEL+FIR_LAT cycles, then moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Delay line: a FIR_LAT-deep pipe carries {phase, idx} for every issued sel.
  - hpass_load=1 when the pipe output is an HPASS entry (15 pulses per block).
  - out_load=1 when the pipe output is a VPASS entry; out_row_idx = idx-16.
- Reference timing (FIR_LAT=2, row_valid tied high, start at edge 0):
  - FILL: cycles 1-15.
  - HPASS: cycles 16-32; sel=0 at 16, sel=14 at 30; hpass_load at 18-32.
  - VPASS: cycles 33-42; out_load at 35-42.
  - done at cycle 43; back in IDLE at cycle 44.
- A row_valid stall of k cycles during FILL delays every later event by k cycles.
- Counters saturate at their terminal count and never wrap mid-state.

Optional Feature:
- Macro: INTERP_SKIP_VPASS_EN.
- Defined, with latched frac_y_q==0: HPASS drives the output directly.
  - out_load=1 when the pipe output is an HPASS entry with idx 3..10.
  - out_row_idx = idx-3.
  - hpass_load still pulses.
  - VPASS is skipped: after HPASS the next state is DONE.
- Defined, with frac_y_q!=0: behaviour is unchanged.
- Undefined: VPASS always runs and out_load never asserts during HPASS.

Test Plan:
- Nominal block, FIR_LAT=2, row_valid=1, start at edge 0, frac=(1,2):
  - 15 row_load pulses at cycles 1-15.
  - hpass_load at 18-32.
  - out_load at 35-42 with out_row_idx 0..7.
  - done only at cycle 43; busy=1 for cycles 1-43.
- FILL backpressure: row_valid low for cycles 5-7 -> exactly 15 row_loads; done moves to cycle 46; sel stays 0 throughout FILL.
- Start ignored while busy: start pulses at cycles 10 and 40 -> no effect; frac_x_q and frac_y_q keep the values latched at cycle 0.
- Reset mid-operation: rst=0 at cycle 25 (HPASS) -> cycle 26 has every output 0 and state IDLE; a new start completes normally with no stale hpass_load.
- Skip path, INTERP_SKIP_VPASS_EN defined, frac_y=0:
  - out_load at cycles 21-28 with out_row_idx 0..7.
  - done at cycle 33.
  - Repeated with frac_y=3: timing identical to the nominal case.
- FIR_LAT=4: hpass_load at 20-34; done at cycle 47.
